// File: rtl/spi_duty_pkg.sv
// Shared types and constants for the SPI duty receiver.
//   - state_e      : receiver FSM states
//   - DEF_*        : default parameter values
//   - cnt_width()  : bit-count width able to hold 0..data_w
package spi_duty_pkg;

    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_OVERRUN = 2'd2
    } state_e;

    // Count must reach data_w itself, hence data_w+1 codes.
    function automatic int unsigned cnt_width(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    localparam int unsigned DEF_CNT_W = cnt_width(DEF_DATA_W);

endpackage

// File: rtl/spi_duty_receiver_sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, chain loads RESET_VAL
//   d      : asynchronous input
//   q      : synchronised output (STAGES flops later)
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the input into bit 0; the oldest sample exits at the top.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/spi_duty_receiver.sv
// SPI (mode 0, active-low select) duty-value receiver in the pwm_clk domain.
// Synchronises the SPI pins, shifts in a frame, commits it only when exactly
// DATA_W bits arrived, and muxes the result against a parallel duty input.
//   pwm_clk         : system clock
//   rst_n           : asynchronous active-low reset
//   chip_select     : SPI select, active-low, asynchronous
//   sclk            : SPI clock, idle low, asynchronous
//   mosi            : SPI data, sampled on sclk rising edge
//   parallel_enable : 1 selects pwm_duty_in for duty_out
//   pwm_duty_in     : parallel duty value
//   duty_out        : registered duty value
//   duty_valid      : one-cycle pulse after duty_out changes value
//   frame_error     : one-cycle pulse on a rejected frame
module spi_duty_receiver
    import spi_duty_pkg::*;
#(
    parameter int unsigned       DATA_W      = DEF_DATA_W,
    parameter int unsigned       LSB_FIRST   = 1,
    parameter logic [DATA_W-1:0] RESET_DUTY  = '0,
    parameter int unsigned       SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              pwm_clk,
    input  logic              rst_n,
    input  logic              chip_select,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              parallel_enable,
    input  logic [DATA_W-1:0] pwm_duty_in,
    output logic [DATA_W-1:0] duty_out,
    output logic              duty_valid,
    output logic              frame_error
);

    localparam int unsigned CNT_W  = cnt_width(DATA_W);
    // Edges are ignored until the chip_select chain and its delayed copy hold
    // real pin samples; otherwise a select held low through reset would look
    // like a falling edge.
    localparam int unsigned WARM_N = SYNC_STAGES + 1;
    localparam int unsigned WARM_W = $clog2(WARM_N + 1);

    logic cs_s;
    logic sclk_s;
    logic mosi_s;

    logic              cs_dly_q,     cs_dly_d;
    logic              sclk_dly_q,   sclk_dly_d;
    logic [WARM_W-1:0] warm_q,       warm_d;
    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic [DATA_W-1:0] spi_duty_q,   spi_duty_d;
    logic [DATA_W-1:0] duty_out_q,   duty_out_d;
    logic [DATA_W-1:0] duty_prev_q,  duty_prev_d;
    logic              duty_valid_q, duty_valid_d;
    logic              frame_err_q,  frame_err_d;

    logic             warm_done_c;
    logic             cs_fall_c;
    logic             cs_rise_c;
    logic             sclk_rise_c;
    logic             frame_full_c;
    logic [CNT_W-1:0] bit_idx_c;

    // Input synchronisers.
    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (pwm_clk),
        .rst_n (rst_n),
        .d     (chip_select),
        .q     (cs_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (pwm_clk),
        .rst_n (rst_n),
        .d     (sclk),
        .q     (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (pwm_clk),
        .rst_n (rst_n),
        .d     (mosi),
        .q     (mosi_s)
    );

    // Edge detection against one-cycle-delayed copies.
    always_comb begin
        cs_dly_d    = cs_s;
        sclk_dly_d  = sclk_s;
        warm_done_c = (warm_q == WARM_W'(WARM_N));
        warm_d      = warm_done_c ? warm_q : warm_q + WARM_W'(1);
        cs_fall_c   = warm_done_c &&  cs_dly_q && !cs_s;
        cs_rise_c   = warm_done_c && !cs_dly_q &&  cs_s;
        sclk_rise_c = sclk_s && !sclk_dly_q;
    end

    // Frame FSM and shift register; frame end has priority over sclk.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        spi_duty_d   = spi_duty_q;
        frame_err_d  = 1'b0;
        frame_full_c = (cnt_q == CNT_W'(DATA_W));

        if (LSB_FIRST != 0) begin
            bit_idx_c = cnt_q;
        end else begin
            bit_idx_c = CNT_W'(DATA_W - 1) - cnt_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                    if (frame_full_c) begin
                        spi_duty_d = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise_c) begin
                    if (frame_full_c) begin
                        state_d = ST_OVERRUN;
                    end else begin
                        for (int i = 0; i < int'(DATA_W); i++) begin
                            if (bit_idx_c == CNT_W'(i)) begin
                                shift_d[i] = mosi_s;
                            end
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OVERRUN: begin
                if (cs_rise_c) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output mux and change-detect strobe.
    always_comb begin
        duty_out_d   = parallel_enable ? pwm_duty_in : spi_duty_q;
        duty_prev_d  = duty_out_q;
        duty_valid_d = (duty_out_q != duty_prev_q);
    end

    always_ff @(posedge pwm_clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_dly_q     <= 1'b1;
            sclk_dly_q   <= 1'b0;
            warm_q       <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            spi_duty_q   <= RESET_DUTY;
            duty_out_q   <= RESET_DUTY;
            duty_prev_q  <= RESET_DUTY;
            duty_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cs_dly_q     <= cs_dly_d;
            sclk_dly_q   <= sclk_dly_d;
            warm_q       <= warm_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            spi_duty_q   <= spi_duty_d;
            duty_out_q   <= duty_out_d;
            duty_prev_q  <= duty_prev_d;
            duty_valid_q <= duty_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign duty_out    = duty_out_q;
    assign duty_valid  = duty_valid_q;
    assign frame_error = frame_err_q;

endmodule
